// File: rtl/ptcalc_div_pkg.sv
// ---------------------------------------------------------------------------
// ptcalc_div_pkg
// Shared widths, output bounds, FSM state constants and arithmetic helpers
// for the 29s / 7ns -> 22s sequential divider.
// ---------------------------------------------------------------------------
package ptcalc_div_pkg;

  localparam int DIVIDEND_WIDTH = 29;
  localparam int DIVISOR_WIDTH  = 7;
  localparam int QUOTIENT_WIDTH = 22;
  // One spare bit above the divisor width keeps the trial compare in range.
  localparam int REM_WIDTH      = DIVISOR_WIDTH + 1;
  localparam int CNT_WIDTH      = 5;
  // Bits of a 29b quotient that must all agree for it to fit in 22b signed.
  localparam int HEAD_WIDTH     = DIVIDEND_WIDTH - QUOTIENT_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0]      CNT_INIT = 5'd28;
  localparam logic [QUOTIENT_WIDTH-1:0] QUOT_MAX = 22'h1F_FFFF;
  localparam logic [QUOTIENT_WIDTH-1:0] QUOT_MIN = 22'h20_0000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

  typedef struct packed {
    logic                      ovf;
    logic [QUOTIENT_WIDTH-1:0] quot;
  } sat_t;

  // Unsigned magnitude of a signed dividend; -2^28 maps to 2^28, which fits.
  function automatic logic [DIVIDEND_WIDTH-1:0] magnitude(input logic [DIVIDEND_WIDTH-1:0] v);
    logic [DIVIDEND_WIDTH-1:0] r;
    if (v[DIVIDEND_WIDTH-1]) begin
      r = ~v + 29'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Two's complement negate of the full 29b quotient when the dividend was negative.
  function automatic logic [DIVIDEND_WIDTH-1:0] apply_sign_quot(input logic [DIVIDEND_WIDTH-1:0] mag,
                                                               input logic neg);
    logic [DIVIDEND_WIDTH-1:0] r;
    if (neg) begin
      r = ~mag + 29'd1;
    end else begin
      r = mag;
    end
    return r;
  endfunction

  // Remainder takes the dividend's sign (truncation toward zero).
  function automatic logic [REM_WIDTH-1:0] apply_sign_rem(input logic [REM_WIDTH-1:0] mag,
                                                          input logic neg);
    logic [REM_WIDTH-1:0] r;
    if (neg) begin
      r = ~mag + 8'd1;
    end else begin
      r = mag;
    end
    return r;
  endfunction

  // Clamp a signed 29b quotient to the signed 22b range and flag clamping.
  function automatic sat_t saturate(input logic [DIVIDEND_WIDTH-1:0] q);
    sat_t                  r;
    logic [HEAD_WIDTH-1:0] head;
    head = q[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH-1];
    if ((&head) || (~|head)) begin
      r.ovf  = 1'b0;
      r.quot = q[QUOTIENT_WIDTH-1:0];
    end else begin
      r.ovf  = 1'b1;
      r.quot = q[DIVIDEND_WIDTH-1] ? QUOT_MIN : QUOT_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/ptcalc_top_div_29s_7ns_22_seq_step.sv
// ---------------------------------------------------------------------------
// ptcalc_top_div_29s_7ns_22_seq_step
// One combinational restoring-division step: shift the partial remainder
// left, bring in the next dividend bit, subtract the divisor if it fits.
// Ports:
//   rem_i      partial remainder in (REM_WIDTH)
//   bit_i      next dividend magnitude bit, MSB first
//   divisor_i  unsigned divisor (DIVISOR_WIDTH)
//   rem_o      partial remainder out (REM_WIDTH)
//   q_bit_o    quotient bit produced by this step
// ---------------------------------------------------------------------------
module ptcalc_top_div_29s_7ns_22_seq_step
  import ptcalc_div_pkg::*;
(
  input  logic [REM_WIDTH-1:0]     rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [REM_WIDTH-1:0]     rem_o,
  output logic                     q_bit_o
);

  logic [REM_WIDTH-1:0] shifted_s;
  logic                 carry_s;
  logic                 ge_s;

  // Trial subtract; the bit shifted out of the top counts as "larger than divisor".
  always_comb begin
    carry_s   = rem_i[REM_WIDTH-1];
    shifted_s = {rem_i[REM_WIDTH-2:0], bit_i};
    ge_s      = carry_s | (shifted_s >= {1'b0, divisor_i});
    if (ge_s) begin
      rem_o = shifted_s - {1'b0, divisor_i};
    end else begin
      rem_o = shifted_s;
    end
    q_bit_o = ge_s;
  end

endmodule

// File: rtl/ptcalc_top_div_29s_7ns_22_seq.sv
// ---------------------------------------------------------------------------
// ptcalc_top_div_29s_7ns_22_seq
// Sequential divider, 29b signed dividend / 7b unsigned divisor -> 22b signed
// quotient, one quotient bit per cycle, start/done handshake. Truncates toward
// zero, saturates out-of-range quotients, flags divide-by-zero.
// Ports:
//   ap_clk, ap_rst_n  clock (rising) and async active-low reset
//   ap_start          request, taken only while idle
//   ap_idle           no operation in flight
//   ap_ready          1-cycle pulse after operands are accepted
//   ap_done           1-cycle pulse when dout/rem/ovf/dz are updated
//   din0, din1        dividend (signed 29b), divisor (unsigned 7b)
//   dout, rem         quotient (signed 22b), remainder (signed 8b)
//   ovf, dz           quotient saturated, divisor was zero
// ---------------------------------------------------------------------------
module ptcalc_top_div_29s_7ns_22_seq
  import ptcalc_div_pkg::*;
(
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  output logic                      ap_idle,
  output logic                      ap_ready,
  output logic                      ap_done,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic [QUOTIENT_WIDTH-1:0] dout,
  output logic [REM_WIDTH-1:0]      rem,
  output logic                      ovf,
  output logic                      dz
);

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] mag_q, mag_d;
  logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
  logic [REM_WIDTH-1:0]      part_q, part_d;
  logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
  logic                      neg_q, neg_d;
  logic [QUOTIENT_WIDTH-1:0] dout_q, dout_d;
  logic [REM_WIDTH-1:0]      rem_q, rem_d;
  logic                      ovf_q, ovf_d;
  logic                      dz_q, dz_d;
  logic                      idle_q, idle_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;

  logic [REM_WIDTH-1:0]      step_rem_s;
  logic                      step_qbit_s;
  logic [DIVIDEND_WIDTH-1:0] quot_signed_s;
  sat_t                      sat_s;

  ptcalc_top_div_29s_7ns_22_seq_step u_step (
    .rem_i     (part_q),
    .bit_i     (mag_q[DIVIDEND_WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_qbit_s)
  );

  // Signed, saturated view of the finished quotient, consumed in FIX.
  always_comb begin
    quot_signed_s = apply_sign_quot(quo_q, neg_q);
    sat_s         = saturate(quot_signed_s);
  end

  // FSM and datapath next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    quo_d   = quo_q;
    part_d  = part_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    idle_d  = idle_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          mag_d   = magnitude(din0);
          neg_d   = din0[DIVIDEND_WIDTH-1];
          dvs_d   = din1;
          part_d  = 8'd0;
          quo_d   = 29'd0;
          cnt_d   = CNT_INIT;
          ready_d = 1'b1;
          idle_d  = 1'b0;
          state_d = ST_CALC;
        end else begin
          idle_d  = 1'b1;
        end
      end
      ST_CALC: begin
        mag_d  = {mag_q[DIVIDEND_WIDTH-2:0], 1'b0};
        part_d = step_rem_s;
        quo_d  = {quo_q[DIVIDEND_WIDTH-2:0], step_qbit_s};
        if (cnt_q == 5'd0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_FIX: begin
        if (dvs_q == 7'd0) begin
          // The core still ran full length; its results are meaningless here.
          dout_d = neg_q ? QUOT_MIN : QUOT_MAX;
          rem_d  = 8'd0;
          ovf_d  = 1'b0;
          dz_d   = 1'b1;
        end else begin
          dout_d = sat_s.quot;
          rem_d  = apply_sign_rem(part_q, neg_q);
          ovf_d  = sat_s.ovf;
          dz_d   = 1'b0;
        end
        done_d  = 1'b1;
        idle_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        idle_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      mag_q   <= 29'd0;
      quo_q   <= 29'd0;
      part_q  <= 8'd0;
      dvs_q   <= 7'd0;
      neg_q   <= 1'b0;
      dout_q  <= 22'd0;
      rem_q   <= 8'd0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      idle_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      quo_q   <= quo_d;
      part_q  <= part_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      idle_q  <= idle_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ap_idle  = idle_q;
  assign ap_ready = ready_q;
  assign ap_done  = done_q;
  assign dout     = dout_q;
  assign rem      = rem_q;
  assign ovf      = ovf_q;
  assign dz       = dz_q;

endmodule

// File: tb/tb_ptcalc_top_div_29s_7ns_22_seq.sv
module tb_ptcalc_top_div_29s_7ns_22_seq;

  localparam longint QMAX = 64'sd2097151;
  localparam longint QMIN = -64'sd2097152;
  localparam int     LAT  = 30;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic [28:0] din0 = 29'd0;
  logic [6:0]  din1 = 7'd0;
  logic        ap_idle, ap_ready, ap_done, ovf, dz;
  logic [21:0] dout;
  logic [7:0]  rem;

  ptcalc_top_div_29s_7ns_22_seq dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .din0(din0), .din1(din1), .dout(dout), .rem(rem), .ovf(ovf), .dz(dz)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint a;
    longint b;
    longint q;
    longint r;
    bit     ovf;
    bit     dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Timing model: one op in flight, result due LAT edges after accept.
  int  cyc = 0;
  bit  m_busy = 1'b0;
  int  m_done_cyc = 0;
  bit  m_ready = 1'b0;
  bit  m_done = 1'b0;
  int  rdy_cnt = 0;
  int  done_cnt = 0;

  function automatic exp_t ref_div(longint a, longint b);
    exp_t   e;
    longint q;
    e.a = a; e.b = b; e.ovf = 1'b0; e.dz = 1'b0;
    if (b == 0) begin
      e.dz = 1'b1;
      e.q  = (a >= 0) ? QMAX : QMIN;
      e.r  = 0;
    end else begin
      q   = a / b;
      e.r = a % b;
      if (q > QMAX) begin
        e.q = QMAX; e.ovf = 1'b1;
      end else if (q < QMIN) begin
        e.q = QMIN; e.ovf = 1'b1;
      end else begin
        e.q = q;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model, evaluated at each active edge from the driven inputs.
  initial forever begin
    @(posedge ap_clk);
    cyc++;
    m_ready = 1'b0;
    m_done  = 1'b0;
    if (!ap_rst_n) begin
      m_busy = 1'b0;
      sb_q.delete();
    end else if (m_busy) begin
      if (cyc == m_done_cyc) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (ap_start) begin
      m_ready    = 1'b1;
      m_busy     = 1'b1;
      m_done_cyc = cyc + LAT;
      sb_q.push_back(ref_div(longint'($signed(din0)), longint'(din1)));
    end
  end

  // Monitor: handshake timing every cycle, result compare on ap_done.
  initial forever begin
    exp_t e;
    @(negedge ap_clk);
    chk("ap_ready", longint'(ap_ready), longint'(m_ready));
    chk("ap_done",  longint'(ap_done),  longint'(m_done));
    chk("ap_idle",  longint'(ap_idle),  longint'(!m_busy));
    if (ap_ready) rdy_cnt++;
    if (ap_done) begin
      done_cnt++;
      chk("sb_nonempty", longint'(sb_q.size() > 0), 64'sd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("dout(%0d/%0d)", e.a, e.b), longint'($signed(dout)), e.q);
        chk($sformatf("rem(%0d/%0d)",  e.a, e.b), longint'($signed(rem)),  e.r);
        chk($sformatf("ovf(%0d/%0d)",  e.a, e.b), longint'(ovf), longint'(e.ovf));
        chk($sformatf("dz(%0d/%0d)",   e.a, e.b), longint'(dz),  longint'(e.dz));
      end
    end
  end

  task automatic do_op(input logic [28:0] a, input logic [6:0] b);
    int guard = 0;
    while (m_busy && guard < 200) begin
      @(negedge ap_clk);
      #2;
      guard++;
    end
    if (guard >= 200) chk("wait_idle_timeout", longint'(m_busy), 64'sd0);
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    @(negedge ap_clk);
    #2;
    // Scramble operands while busy: result must not depend on them.
    ap_start = 1'b0;
    din0 = 29'($urandom);
    din1 = 7'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_busy || sb_q.size() > 0) && guard < 200) begin
      @(negedge ap_clk);
      #2;
      guard++;
    end
    chk("drain", longint'(sb_q.size()), 64'sd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, longint'(dout), 64'sd0);
    chk({tag, "_rem"},  longint'(rem),  64'sd0);
    chk({tag, "_ovf"},  longint'(ovf),  64'sd0);
    chk({tag, "_dz"},   longint'(dz),   64'sd0);
    chk({tag, "_idle"}, longint'(ap_idle), 64'sd1);
  endtask

  longint da[12] = '{1000, -1000, 7, 268435455, -268435456, -268435456,
                     4194302, -4194304, 555, -5, 0, 0};
  longint db[12] = '{7, 7, 100, 1, 1, 127, 2, 2, 0, 0, 5, 0};

  initial begin
    int r0, d0, sel;
    logic [28:0] ra;
    logic [6:0]  rb;
    repeat (3) @(negedge ap_clk);
    chk_reset_outputs("reset");
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    #2;

    // Directed cases, issued back to back.
    for (int i = 0; i < 12; i++) do_op(29'(da[i]), 7'(db[i]));
    drain();

    // ap_start held high 40 cycles: accept, done after LAT, re-accept next cycle.
    r0 = rdy_cnt;
    d0 = done_cnt;
    ap_start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din0 = 29'($urandom);
      din1 = 7'($urandom);
      @(negedge ap_clk);
      #2;
    end
    ap_start = 1'b0;
    chk("held_start_accepts", longint'(rdy_cnt - r0), 64'sd2);
    chk("held_start_dones",   longint'(done_cnt - d0), 64'sd1);
    drain();

    // Reset in the middle of CALC after a result with nonzero flags.
    do_op(-29'sd5, 7'd0);
    drain();
    d0 = done_cnt;
    do_op(29'd123456, 7'd5);
    repeat (9) @(negedge ap_clk);
    #1 ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    #2;
    chk_reset_outputs("midcalc_reset");
    #1 ap_rst_n = 1'b1;
    repeat (40) @(negedge ap_clk);
    #2;
    chk("aborted_no_done", longint'(done_cnt - d0), 64'sd0);
    do_op(29'd9, 7'd3);
    drain();

    // Randomized pairs, biased toward the range extremes and zero divisor.
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       ra = 29'h1000_0000;
        1:       ra = 29'h0FFF_FFFF;
        2:       ra = 29'($signed($urandom_range(0, 2000)) - 1000);
        3:       ra = 29'($urandom_range(0, 4194304)) ^ {29{$urandom_range(0, 1) == 1}};
        default: ra = 29'($urandom);
      endcase
      rb = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom);
      do_op(ra, rb);
    end
    drain();
    repeat (3) @(negedge ap_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
